sprite_line_fetch: RTL and testbench

- Sits directly downstream of the print FSM.
- Consumes `sprite_on` and `sprite_datas` and walks the visible remainder of one sprite row on the current scanline.
- Emits one sprite-memory address per `clk`, then pulses `count_finished` back to the print FSM so it can return to its receive state.
- Owns the per-sprite pixel counter that the print FSM waits on.

---
 rtl/sprite_line_fetch_if.sv | 27 ++
 rtl/sprite_line_fetch.sv | 128 ++++++++++++
 tb/tb_sprite_line_fetch.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/sprite_line_fetch_if.sv
// Handshake and address bundle between the print FSM and the sprite row fetcher.
// The master side is the print FSM; the slave side is sprite_line_fetch.
interface sprite_line_fetch_if #(
  parameter int size_x       = 10,
  parameter int size_y       = 10,
  parameter int size_address = 14
);
  logic                    sprite_on;
  logic [31:0]             sprite_datas;
  logic [size_x-1:0]       pixel_x;
  logic [size_y-1:0]       pixel_y;
  logic [size_address-1:0] memory_address;
  logic                    addr_valid;
  logic                    count_finished;
  logic                    busy;
  logic                    error;

  modport master (
    output sprite_on, sprite_datas, pixel_x, pixel_y,
    input  memory_address, addr_valid, count_finished, busy, error
  );

  modport slave (
    input  sprite_on, sprite_datas, pixel_x, pixel_y,
    output memory_address, addr_valid, count_finished, busy, error
  );
endinterface

// File: rtl/sprite_line_fetch.sv
// Walks the visible remainder of one sprite row on the current scanline,
// emitting one sprite-memory address per clock, then pulses count_finished.
//
// state | meaning
// IDLE  | waiting for a sprite_on rising edge
// LOAD  | compute row, first column and row base address; validate descriptor
// RUN   | emit base + col each cycle until the last sprite column
// DONE  | one-cycle count_finished pulse back to the print FSM
module sprite_line_fetch #(
  parameter int size_x       = 10,
  parameter int size_y       = 10,
  parameter int size_address = 14,
  parameter int SPRITE_SIZE  = 20,
  parameter int MAX_SPRITES  = 40
) (
  input logic               clk,
  input logic               reset,
  sprite_line_fetch_if.slave bus
);

  localparam int COL_W = $clog2(SPRITE_SIZE);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t                  state;
  logic                    sprite_on_d;
  logic [size_address-1:0] base;
  logic [COL_W-1:0]        col;
  logic [size_address-1:0] memory_address;
  logic                    addr_valid;
  logic                    count_finished;
  logic                    busy;
  logic                    error;

  logic [9:0]  x_origin;
  logic [9:0]  y_origin;
  logic [8:0]  index;
  logic [10:0] row_c;
  logic [10:0] col_c;
  logic [15:0] base_wide;
  logic        bad_desc;
  logic        start;
  logic        unused_bits;

  assign x_origin = bus.sprite_datas[28:19];
  assign y_origin = bus.sprite_datas[18:9];
  assign index    = bus.sprite_datas[8:0];
  assign start    = bus.sprite_on & ~sprite_on_d;

  // Borrow out of the 11-bit subtraction lands in bit 10, which also makes it >= SPRITE_SIZE.
  always_comb begin
    row_c     = 11'(bus.pixel_y) - 11'(y_origin);
    col_c     = 11'(bus.pixel_x) - 11'(x_origin);
    base_wide = 16'(index) * 16'(SPRITE_SIZE * SPRITE_SIZE) + 16'(row_c) * 16'(SPRITE_SIZE);
    bad_desc  = row_c[10] | col_c[10]
              | (row_c >= 11'(SPRITE_SIZE))
              | (col_c >= 11'(SPRITE_SIZE))
              | (index >= 9'(MAX_SPRITES));
  end

  assign unused_bits = &{1'b0, bus.sprite_datas[31:29], base_wide[15:size_address]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      sprite_on_d    <= 1'b0;
      base           <= '0;
      col            <= '0;
      memory_address <= '0;
      addr_valid     <= 1'b0;
      count_finished <= 1'b0;
      busy           <= 1'b0;
      error          <= 1'b0;
    end else begin
      sprite_on_d    <= bus.sprite_on;
      count_finished <= 1'b0;
      case (state)
        IDLE: begin
          addr_valid <= 1'b0;
          busy       <= start;
          if (start) state <= LOAD;
        end
        LOAD: begin
          if (!bus.sprite_on) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (bad_desc) begin
            error <= 1'b1;
            state <= DONE;
          end else begin
            base  <= base_wide[size_address-1:0];
            col   <= col_c[COL_W-1:0];
            state <= RUN;
          end
        end
        RUN: begin
          if (!bus.sprite_on) begin
            state      <= IDLE;
            addr_valid <= 1'b0;
            busy       <= 1'b0;
          end else begin
            memory_address <= base + {{(size_address-COL_W){1'b0}}, col};
            addr_valid     <= 1'b1;
            col            <= col + 1'b1;
            if (col == COL_W'(SPRITE_SIZE - 1)) state <= DONE;
          end
        end
        DONE: begin
          addr_valid     <= 1'b0;
          count_finished <= 1'b1;
          state          <= IDLE;
        end
        default: begin
          state      <= IDLE;
          addr_valid <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.memory_address = memory_address;
  assign bus.addr_valid     = addr_valid;
  assign bus.count_finished = count_finished;
  assign bus.busy           = busy;
  assign bus.error          = error;

endmodule

// File: tb/tb_sprite_line_fetch.sv
// Randomized bench for sprite_line_fetch against an arithmetic model of one sprite row.
module tb_sprite_line_fetch;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sprite_line_fetch_if bus ();

  sprite_line_fetch dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  bit exp_err = 1'b0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_desc(input int x, input int y, input int idx, input int px, input int py);
    logic [9:0] xv, yv, pxv, pyv;
    logic [8:0] iv;
    xv = 10'(x); yv = 10'(y); iv = 9'(idx); pxv = 10'(px); pyv = 10'(py);
    bus.sprite_datas = {3'b101, xv, yv, iv};
    bus.pixel_x      = pxv;
    bus.pixel_y      = pyv;
  endtask

  // One fetch: model the expected address list, raise sprite_on, observe 45 cycles.
  task automatic fetch(input int x, input int y, input int idx, input int px, input int py,
                       input int abort_n);
    int  row, col0, n_exp, exp_cnt, first, last, fin_at, fin_cnt;
    bit  bad, aborted;
    int  exp_q[$];
    int  got[$];
    row  = py - y;
    col0 = px - x;
    bad  = (row < 0) || (row >= 20) || (col0 < 0) || (col0 >= 20) || (idx >= 40);
    if (!bad)
      for (int c = col0; c < 20; c++) exp_q.push_back((idx * 400 + row * 20 + c) % 16384);
    if (bad) exp_err = 1'b1;
    n_exp   = exp_q.size();
    aborted = (abort_n > 0) && (abort_n < n_exp);
    exp_cnt = aborted ? abort_n : n_exp;
    first = -1; last = -1; fin_at = -1; fin_cnt = 0;

    @(negedge clk);
    set_desc(x, y, idx, px, py);
    bus.sprite_on = 1'b1;
    for (int cyc = 1; cyc <= 45; cyc++) begin
      @(negedge clk);
      if (cyc == 1) check("busy_after_start", bus.busy, 1);
      if (bus.addr_valid) begin
        if (first < 0) first = cyc;
        last = cyc;
        got.push_back(int'(bus.memory_address));
      end
      if (bus.count_finished) begin
        fin_cnt++;
        if (fin_at < 0) fin_at = cyc;
      end
      if (aborted && bus.sprite_on && got.size() == abort_n) bus.sprite_on = 1'b0;
    end
    check("busy_settled", bus.busy, 0);
    bus.sprite_on = 1'b0;

    check("addr_count", got.size(), exp_cnt);
    for (int i = 0; i < got.size() && i < exp_cnt; i++) check("addr", got[i], exp_q[i]);
    check("first_valid_cycle", first, (exp_cnt > 0) ? 3 : -1);
    if (exp_cnt > 0) check("valid_span", last - first + 1, exp_cnt);
    check("finish_pulses", fin_cnt, aborted ? 0 : 1);
    if (!aborted) check("finish_cycle", fin_at, 3 + n_exp);
    check("error_flag", bus.error, int'(exp_err));
    @(negedge clk);
  endtask

  initial begin
    int activity;
    int rx, ry, ridx, rab;
    reset            = 1'b1;
    bus.sprite_on    = 1'b0;
    bus.sprite_datas = '0;
    bus.pixel_x      = '0;
    bus.pixel_y      = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_addr", bus.memory_address, 0);
    check("rst_valid", bus.addr_valid, 0);
    check("rst_finished", bus.count_finished, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_error", bus.error, 0);

    activity = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      activity += bus.addr_valid + bus.count_finished + bus.busy;
    end
    check("idle_activity", activity, 0);

    fetch(100, 50, 2, 100, 53, 0);
    fetch(100, 50, 2, 117, 53, 0);
    fetch(100, 50, 2, 100, 70, 0);
    fetch(100, 50, 40, 100, 53, 0);
    fetch(100, 50, 2, 99, 53, 0);
    fetch(100, 50, 2, 100, 53, 0);
    fetch(100, 50, 2, 100, 53, 5);
    fetch(100, 50, 2, 100, 53, 0);
    fetch(0, 0, 39, 19, 19, 0);

    for (int k = 0; k < 25; k++) begin
      rx   = $urandom_range(3, 900);
      ry   = $urandom_range(3, 900);
      ridx = $urandom_range(0, 45);
      rab  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 19) : 0;
      fetch(rx, ry, ridx, rx - 3 + $urandom_range(0, 25), ry - 3 + $urandom_range(0, 25), rab);
    end

    // Asynchronous reset between clock edges while addresses are streaming.
    @(negedge clk);
    set_desc(100, 50, 2, 100, 53);
    bus.sprite_on = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("pre_reset_valid", bus.addr_valid, 1);
    #1;
    reset = 1'b1;
    bus.sprite_on = 1'b0;
    #1;
    exp_err = 1'b0;
    check("async_rst_valid", bus.addr_valid, 0);
    check("async_rst_addr", bus.memory_address, 0);
    check("async_rst_busy", bus.busy, 0);
    check("async_rst_finished", bus.count_finished, 0);
    check("async_rst_error", bus.error, 0);
    @(negedge clk);
    reset = 1'b0;
    activity = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      activity += bus.busy + bus.addr_valid + bus.count_finished;
    end
    check("post_reset_quiet", activity, 0);
    fetch(100, 50, 2, 110, 60, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
